// File: rtl/u_stream.sv
// u_stream: valid/ready classifier for unary (thermometer) codes and their complements.
// Results pass through a 2-entry main/skid buffer. The error counter is built only when `U_STREAM_ERR_CNT_EN is defined.
module u_stream #(
   parameter int W                     = 16,
   parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1,
   parameter int ERR_CNT_W             = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_vld,
   input  logic [W-1:0]         i_x,
   output logic                 o_rdy,
   output logic                 o_vld,
   input  logic                 i_rdy,
   output logic                 o_is_unary,
   output logic                 o_is_compliment,
   output logic [$clog2(W)-1:0] o_len,
   input  logic                 i_err_clr,
   output logic [ERR_CNT_W-1:0] o_err_cnt
);

   localparam int LW = $clog2(W);
   localparam int EW = LW + 2;

   logic [W-1:0]  w_inv;
   logic          w_isStd;
   logic          w_isCmp;
   logic          w_unary;
   logic [LW-1:0] w_stdLen;
   logic [LW-1:0] w_cmpLen;
   logic [LW-1:0] w_len;
   logic [EW-1:0] w_entry;
   logic          w_acc;
   logic          w_emit;

   logic [EW-1:0] r_main;
   logic [EW-1:0] r_skid;
   logic          r_mainVld;
   logic          r_skidVld;
   logic          r_rdy;

   logic [EW-1:0] w_mainNxt;
   logic [EW-1:0] w_skidNxt;
   logic          w_mainVldNxt;
   logic          w_skidVldNxt;

   // A run of ones from bit 0 has no carry overlap with x+1.
   // All-ones is excluded, so the standard and complement sets stay disjoint.
   assign w_inv   = ~i_x;
   assign w_isStd = ((i_x & (i_x + W'(1))) == '0) && (i_x != '1);
   assign w_isCmp = P_ADMIT_COMPLIMENT_EN && ((w_inv & (w_inv + W'(1))) == '0) && (i_x != '0);
   assign w_unary = w_isStd | w_isCmp;

   // For an admitted code the top bit never contributes, so W-1 bits keep the count within LW bits.
   always_comb begin
      w_stdLen = '0;
      w_cmpLen = '0;
      for (int i = 0; i < W - 1; i++) begin
         w_stdLen = w_stdLen + LW'(i_x[i]);
         w_cmpLen = w_cmpLen + LW'(w_inv[i]);
      end
   end

   assign w_len   = w_isStd ? w_stdLen : (w_isCmp ? w_cmpLen : '0);
   assign w_entry = {w_unary, w_isCmp, w_len};

   assign w_acc  = i_vld & r_rdy;
   assign w_emit = r_mainVld & i_rdy;

   always_comb begin
      w_mainNxt    = r_main;
      w_skidNxt    = r_skid;
      w_mainVldNxt = r_mainVld;
      w_skidVldNxt = r_skidVld;
      if (r_skidVld) begin
         if (w_emit) begin
            w_mainNxt    = r_skid;
            w_skidVldNxt = 1'b0;
         end
      end else if (r_mainVld) begin
         if (w_emit && w_acc) begin
            w_mainNxt = w_entry;
         end else if (w_emit) begin
            w_mainVldNxt = 1'b0;
         end else if (w_acc) begin
            w_skidNxt    = w_entry;
            w_skidVldNxt = 1'b1;
         end
      end else if (w_acc) begin
         w_mainNxt    = w_entry;
         w_mainVldNxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_main    <= '0;
         r_skid    <= '0;
         r_mainVld <= 1'b0;
         r_skidVld <= 1'b0;
         r_rdy     <= 1'b0;
      end else begin
         r_main    <= w_mainNxt;
         r_skid    <= w_skidNxt;
         r_mainVld <= w_mainVldNxt;
         r_skidVld <= w_skidVldNxt;
         r_rdy     <= ~w_skidVldNxt;
      end
   end

   assign o_vld = r_mainVld;
   assign o_rdy = r_rdy;
   assign {o_is_unary, o_is_compliment, o_len} = r_main;

`ifdef U_STREAM_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] r_errCnt;

   // Counting happens at accept time. A clear wins over a same-cycle reject.
   always_ff @(posedge clk) begin
      if (!rst_n || i_err_clr) begin
         r_errCnt <= '0;
      end else if (w_acc && !w_unary && (r_errCnt != '1)) begin
         r_errCnt <= r_errCnt + ERR_CNT_W'(1);
      end
   end

   assign o_err_cnt = r_errCnt;
`else
   logic w_unused;
   assign w_unused  = i_err_clr;
   assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_u_stream.sv
// tb_u_stream: directed, table-driven bench for u_stream (W=8).
// Covers both the complement-enabled and complement-disabled instances.
module tb_u_stream;

   localparam int W = 8;
`ifdef U_STREAM_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] x;
      logic       u;
      logic       c;
      logic [2:0] len;
      logic       u2;
      logic [2:0] len2;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_vld;
   logic [7:0] i_x;
   logic       i_rdy;
   logic       i_err_clr;

   logic       o_rdy, o_vld, o_is_unary, o_is_compliment;
   logic [2:0] o_len;
   logic [7:0] o_err_cnt;
   logic       o_rdyB, o_vldB, o_is_unaryB, o_is_complimentB;
   logic [2:0] o_lenB;
   logic [7:0] o_err_cntB;

   int   total = 0;
   int   bad = 0;
   int   errModel = 0;
   vec_t tbl [13];

   always #5 clk = ~clk;

   u_stream #(.W(W), .P_ADMIT_COMPLIMENT_EN(1'b1), .ERR_CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_x(i_x), .o_rdy(o_rdy), .o_vld(o_vld),
      .i_rdy(i_rdy), .o_is_unary(o_is_unary), .o_is_compliment(o_is_compliment),
      .o_len(o_len), .i_err_clr(i_err_clr), .o_err_cnt(o_err_cnt)
   );

   u_stream #(.W(W), .P_ADMIT_COMPLIMENT_EN(1'b0), .ERR_CNT_W(8)) dutNoCmp (
      .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_x(i_x), .o_rdy(o_rdyB), .o_vld(o_vldB),
      .i_rdy(i_rdy), .o_is_unary(o_is_unaryB), .o_is_compliment(o_is_complimentB),
      .o_len(o_lenB), .i_err_clr(i_err_clr), .o_err_cnt(o_err_cntB)
   );

   // Drive one cycle of inputs, then step to just after the rising edge.
   task automatic applyStimulus(input logic vld, input logic [7:0] x, input logic rdy, input logic clr);
      i_vld     = vld;
      i_x       = x;
      i_rdy     = rdy;
      i_err_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input int unsigned got, input int unsigned want);
      total++;
      if (got != want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Reference error counter, updated with whatever the last edge accepted.
   task automatic bumpErr(input bit rejectedAccept, input bit clr);
      if (!ERR_EN || clr) errModel = 0;
      else if (rejectedAccept && errModel < 255) errModel++;
   endtask

   initial begin
      tbl[0]  = '{8'h07, 1'b1, 1'b0, 3'd3, 1'b1, 3'd3};
      tbl[1]  = '{8'hF8, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0};
      tbl[2]  = '{8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0};
      tbl[3]  = '{8'hFF, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0};
      tbl[4]  = '{8'h05, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0};
      tbl[5]  = '{8'h01, 1'b1, 1'b0, 3'd1, 1'b1, 3'd1};
      tbl[6]  = '{8'h7F, 1'b1, 1'b0, 3'd7, 1'b1, 3'd7};
      tbl[7]  = '{8'h80, 1'b1, 1'b1, 3'd7, 1'b0, 3'd0};
      tbl[8]  = '{8'hFE, 1'b1, 1'b1, 3'd1, 1'b0, 3'd0};
      tbl[9]  = '{8'h81, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0};
      tbl[10] = '{8'h3F, 1'b1, 1'b0, 3'd6, 1'b1, 3'd6};
      tbl[11] = '{8'hE0, 1'b1, 1'b1, 3'd5, 1'b0, 3'd0};
      tbl[12] = '{8'hC0, 1'b1, 1'b1, 3'd6, 1'b0, 3'd0};

      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("rst_vld", o_vld, 0);
      checkOutput("rst_rdy", o_rdy, 0);
      checkOutput("rst_unary", o_is_unary, 0);
      checkOutput("rst_compl", o_is_compliment, 0);
      checkOutput("rst_len", o_len, 0);
      checkOutput("rst_err", o_err_cnt, 0);

      rst_n = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("post_rst_rdy", o_rdy, 1);
      checkOutput("post_rst_vld", o_vld, 0);

      // Back-to-back stream at full throughput: each word appears right after its accept edge.
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b1, tbl[i].x, 1'b1, 1'b0);
         bumpErr(!tbl[i].u, 1'b0);
         checkOutput($sformatf("vec%0d_vld", i), o_vld, 1);
         checkOutput($sformatf("vec%0d_rdy", i), o_rdy, 1);
         checkOutput($sformatf("vec%0d_unary", i), o_is_unary, tbl[i].u);
         checkOutput($sformatf("vec%0d_compl", i), o_is_compliment, tbl[i].c);
         checkOutput($sformatf("vec%0d_len", i), o_len, tbl[i].len);
         checkOutput($sformatf("vec%0d_err", i), o_err_cnt, errModel);
         checkOutput($sformatf("vec%0d_nocmp_unary", i), o_is_unaryB, tbl[i].u2);
         checkOutput($sformatf("vec%0d_nocmp_compl", i), o_is_complimentB, 0);
         checkOutput($sformatf("vec%0d_nocmp_len", i), o_lenB, tbl[i].len2);
      end
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_vld", o_vld, 0);

      // Back-pressure: A=03, B=F0 fill the buffer, C=3F must wait.
      applyStimulus(1'b1, 8'h03, 1'b0, 1'b0);
      checkOutput("bp_a_vld", o_vld, 1);
      checkOutput("bp_a_rdy", o_rdy, 1);
      checkOutput("bp_a_len", o_len, 2);
      applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0);
      checkOutput("bp_full_rdy", o_rdy, 0);
      checkOutput("bp_hold_a_len", o_len, 2);
      applyStimulus(1'b1, 8'h3F, 1'b0, 1'b0);
      checkOutput("bp_stall_rdy", o_rdy, 0);
      checkOutput("bp_stall_len", o_len, 2);
      checkOutput("bp_stall_compl", o_is_compliment, 0);
      applyStimulus(1'b1, 8'h3F, 1'b1, 1'b0);
      checkOutput("bp_b_vld", o_vld, 1);
      checkOutput("bp_b_len", o_len, 4);
      checkOutput("bp_b_compl", o_is_compliment, 1);
      checkOutput("bp_b_rdy", o_rdy, 1);
      applyStimulus(1'b1, 8'h3F, 1'b1, 1'b0);
      checkOutput("bp_c_vld", o_vld, 1);
      checkOutput("bp_c_len", o_len, 6);
      checkOutput("bp_c_compl", o_is_compliment, 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("bp_empty_vld", o_vld, 0);

      // Saturation, then a clear that coincides with a rejected accept.
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
      bumpErr(1'b0, 1'b1);
      checkOutput("sat_clr_err", o_err_cnt, errModel);
      for (int i = 0; i < 260; i++) begin
         applyStimulus(1'b1, 8'h05, 1'b1, 1'b0);
         bumpErr(1'b1, 1'b0);
         if (i == 9) checkOutput("sat_mid_err", o_err_cnt, errModel);
      end
      checkOutput("sat_err", o_err_cnt, ERR_EN ? 255 : 0);
      checkOutput("sat_model_err", o_err_cnt, errModel);
      applyStimulus(1'b1, 8'h05, 1'b1, 1'b1);
      bumpErr(1'b1, 1'b1);
      checkOutput("clr_prio_err", o_err_cnt, 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset with two entries buffered.
      applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
      bumpErr(1'b1, 1'b0);
      applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
      bumpErr(1'b1, 1'b0);
      checkOutput("mr_full_rdy", o_rdy, 0);
      checkOutput("mr_full_vld", o_vld, 1);
      checkOutput("mr_full_err", o_err_cnt, errModel);
      rst_n = 1'b0;
      applyStimulus(1'b1, 8'h07, 1'b1, 1'b0);
      errModel = 0;
      checkOutput("mr_vld", o_vld, 0);
      checkOutput("mr_rdy", o_rdy, 0);
      checkOutput("mr_err", o_err_cnt, errModel);
      checkOutput("mr_unary", o_is_unary, 0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("mr_post_rdy", o_rdy, 1);
      checkOutput("mr_post_vld", o_vld, 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("mr_no_emit_vld", o_vld, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/u_stream.md
# u_stream

Registered, flow-controlled successor to the combinational unary admission check. Accepts one W-bit word per cycle on a valid/ready interface and classifies it as a unary/thermometer code or its complement. Each valid word is decoded to a binary run length, and an optional saturating error counter tallies rejected words. Sits between a thermometer-coded producer (FIFO occupancy, ADC flash output, priority masks) and binary-domain consumers.

## Interface
- `W`, default 16: input word width; legal range W ≥ 2.
- `P_ADMIT_COMPLIMENT_EN`, default 1: admit the complemented code.
- `ERR_CNT_W`, default 8: error counter width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `i_vld`  in  1  input word valid.
- `i_x`  in  W  input word.
- `o_rdy`  out  1  block can accept a word; registered.
- `o_vld`  out  1  result valid.
- `i_rdy`  in  1  downstream accepts the result.
- `o_is_unary`  out  1  word is an admitted code.
- `o_is_compliment`  out  1  admitted word is the complemented form.
- `o_len`  out  $clog2(W)  decoded run length.
- `i_err_clr`  in  1  clear the error counter.
- `o_err_cnt`  out  ERR_CNT_W  saturating count of rejected words.

## Operation
- Accept occurs when `i_vld & o_rdy`. Emit occurs when `o_vld & i_rdy`. Word order is preserved, and no word is dropped or duplicated.
- Standard code: `i_x` equals `(1<<k)-1` for k in 0..W-1.
  - All-zero is admitted with k=0.
  - All-ones is not a standard code.
  - Result: `o_is_unary=1`, `o_is_compliment=0`, `o_len=k`.
- Complement code, only when `P_ADMIT_COMPLIMENT_EN=1`: `i_x` equals `~((1<<k)-1)` for k in 0..W-1.
  - All-ones is admitted with k=0.
  - Result: `o_is_unary=1`, `o_is_compliment=1`, `o_len=k` (count of trailing zeros).
- Any other word is rejected: `o_is_unary=0`, `o_is_compliment=0`, `o_len=0`.
- With `P_ADMIT_COMPLIMENT_EN=0`, `o_is_compliment` is constant 0 and complement patterns other than all-zero are rejected.
- Classification and decode are computed combinationally on `i_x`. The result is captured into a 2-entry output buffer made of a main register plus a skid register.
- Buffer occupancy is 0, 1 or 2.
  - `o_vld` = (occupancy ≥ 1).
  - `o_rdy` = (occupancy < 2), driven from a register.
  - Outputs always present the oldest entry.
- Simultaneous accept and emit leave occupancy unchanged and give full throughput, one word per cycle.
- Error counter, on each accepted rejected word:
  - Increments by 1 and saturates at 2^ERR_CNT_W − 1 (no wrap).
  - `i_err_clr` zeroes the counter and has priority over a same-cycle increment, so the result is 0.
  - Counting happens at accept, not at emit.

## Timing
- Latency is 1 cycle: a word accepted at edge n is presented with `o_vld=1` after edge n.
- A word is held stable while `o_vld & !i_rdy`.
- `o_rdy` deasserts the cycle after the second unemitted entry is captured. It reasserts the cycle after an emit frees an entry.
- Reset values while `rst_n=0` and after the first edge with `rst_n=0`:
  - `o_vld=0`, `o_rdy=0`.
  - `o_is_unary=0`, `o_is_compliment=0`, `o_len=0`.
  - `o_err_cnt=0`.
  - Occupancy 0.
- `o_rdy=1` from the first edge with `rst_n=1`.
- Reset mid-operation discards all buffered entries with no emit. `i_vld`/`i_rdy` during reset are ignored.
- `o_err_cnt` updates on the edge following the accept of a rejected word.

## Configuration
- Macro `U_STREAM_ERR_CNT_EN`.
- Defined: the error counter is implemented as described above.
- Undefined:
  - No counter flops are built.
  - `o_err_cnt` is tied to 0.
  - `i_err_clr` is unused and tied off.
  - All other behaviour is identical.

## Test plan
All cases use W=8, `P_ADMIT_COMPLIMENT_EN=1`, `U_STREAM_ERR_CNT_EN` defined, `i_rdy=1` unless stated.
- Decode: send `0000_0111`, then `1111_1000`, then `0000_0000`, then `1111_1111` back-to-back. Required results, one per cycle starting 1 cycle after the first accept:
  - (1,0,3), (1,1,3), (1,0,0), (1,1,0).
- Reject: send `0000_0101`. Required: `o_is_unary=0`, `o_len=0`, and `o_err_cnt` 0→1.
- Back-pressure: hold `i_rdy=0` and drive 3 words A, B, C.
  - A and B are accepted; `o_rdy=0` from then on; C is held.
  - Raise `i_rdy`: A, B, C emerge in order with no loss.
- Saturation/clear: accept 260 rejected words and check `o_err_cnt=255`. Then assert `i_err_clr` in the same cycle as another rejected accept; required `o_err_cnt=0`.
- Reset mid-stream: with 2 entries buffered, pulse `rst_n=0` for 1 cycle.
  - Required: `o_vld=0` and `o_err_cnt=0`; nothing is emitted.
  - `o_rdy=1` the first cycle after `rst_n` returns high.
- Complement disabled (`P_ADMIT_COMPLIMENT_EN=0`): `1111_1000` → `o_is_unary=0`, `o_is_compliment=0`; `0000_0000` → (1,0,0).
